// File: rtl/dram_cell_fetch.sv
// Scan-out engine: walks a contiguous data-memory region one word per cycle,
// unpacks each word into {char, rgb} cells and buffers them for a consumer.
module dram_cell_fetch #(
   parameter logic [13:0] BASE_ADDR  = 14'h0400,
   parameter int unsigned NUM_CELLS  = 64,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [13:0] mem_a,
   input  logic [31:0] mem_rd,
   output logic        cell_valid,
   input  logic        cell_ready,
   output logic [7:0]  cell_char,
   output logic [23:0] cell_rgb,
   output logic        cell_last,
   output logic        busy,
   output logic        done
);

   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned CELL_W = 13;
   localparam int unsigned ENT_W  = 33;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ENT_W-1:0]    r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [CELL_W-1:0]   r_cell_cnt;
   logic [13:0]         r_mem_a;
   logic                r_busy;
   logic                r_done;
   logic                w_push;
   logic                w_pop;
   logic                w_last;
   logic                w_done_nxt;
   logic [ENT_W-1:0]    w_head;

   assign w_last = (r_cell_cnt == CELL_W'(NUM_CELLS - 1));
   assign w_pop  = (r_count != '0) && cell_ready;
   assign w_head = r_fifo[r_rd_ptr];

   // Next-state and push decision; fullness is taken from the registered count only
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            w_push = (r_count < CNT_W'(FIFO_DEPTH));
            if (w_push && w_last) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_count == '0) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= w_done_nxt;
      end
   end

   // Address and cell counter re-arm whenever the engine is (or returns to) idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_a    <= BASE_ADDR;
         r_cell_cnt <= '0;
      end else if (w_state_nxt == S_IDLE) begin
         r_mem_a    <= BASE_ADDR;
         r_cell_cnt <= '0;
      end else if (w_push) begin
         r_mem_a    <= r_mem_a + 14'd4;
         r_cell_cnt <= r_cell_cnt + CELL_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) r_fifo[i] <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= {w_last, mem_rd};
            r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign mem_a      = r_mem_a;
   assign cell_valid = (r_count != '0);
   assign cell_char  = w_head[7:0];
   assign cell_rgb   = w_head[31:8];
   assign cell_last  = w_head[32];
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_dram_cell_fetch.sv
// Directed bench for dram_cell_fetch: a 6-cell scan at 0x0400 and a 4-cell scan
// that wraps the 14-bit address space.
module tb_dram_cell_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_start, a_ready, a_valid, a_last, a_busy, a_done;
   logic [13:0] a_mem_a;
   logic [31:0] a_mem_rd;
   logic [7:0]  a_char;
   logic [23:0] a_rgb;
   logic        w_start, w_ready, w_valid, w_last, w_busy, w_done;
   logic [13:0] w_mem_a;
   logic [31:0] w_mem_rd;
   logic [7:0]  w_char;
   logic [23:0] w_rgb;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   // Memory contents: 0x0400 holds the reference cell, others are address-tagged
   function automatic logic [31:0] mem_word(input logic [13:0] a);
      if (a == 14'h0400) return 32'hFF000041;
      return {2'b01, a, 8'h3C, 8'h41 + a[9:2]};
   endfunction

   assign a_mem_rd = mem_word(a_mem_a);
   assign w_mem_rd = mem_word(w_mem_a);

   dram_cell_fetch #(.BASE_ADDR(14'h0400), .NUM_CELLS(6), .FIFO_DEPTH(4)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .mem_a(a_mem_a), .mem_rd(a_mem_rd),
      .cell_valid(a_valid), .cell_ready(a_ready), .cell_char(a_char), .cell_rgb(a_rgb),
      .cell_last(a_last), .busy(a_busy), .done(a_done));

   dram_cell_fetch #(.BASE_ADDR(14'h3FF8), .NUM_CELLS(4), .FIFO_DEPTH(4)) u_w (
      .clk(clk), .rst(rst), .start(w_start), .mem_a(w_mem_a), .mem_rd(w_mem_rd),
      .cell_valid(w_valid), .cell_ready(w_ready), .cell_char(w_char), .cell_rgb(w_rgb),
      .cell_last(w_last), .busy(w_busy), .done(w_done));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_head_a(input string name, input logic [13:0] addr, input logic exp_last);
      logic [31:0] w;
      w = mem_word(addr);
      chk({name, "_char"}, 32'(a_char), 32'(w[7:0]));
      chk({name, "_rgb"},  32'(a_rgb),  32'(w[31:8]));
      chk({name, "_last"}, 32'(a_last), 32'(exp_last));
   endtask

   typedef struct {
      logic        start;
      logic        ready;
      logic [13:0] mem_a;
      logic        valid;
      logic [13:0] head_a;
      logic        last;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t vt[11];

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int idx, ndone, pops;
      logic [13:0] exp_q[5];
      logic [13:0] exp_a;
      logic [31:0] w;

      // cycle-by-cycle image of a 6-cell scan with the consumer always ready
      vt[0]  = '{1'b1, 1'b1, 14'h0400, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 14'h0400, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 14'h0404, 1'b1, 14'h0400, 1'b0, 1'b1, 1'b0};
      vt[3]  = '{1'b0, 1'b1, 14'h0408, 1'b1, 14'h0404, 1'b0, 1'b1, 1'b0};
      vt[4]  = '{1'b0, 1'b1, 14'h040C, 1'b1, 14'h0408, 1'b0, 1'b1, 1'b0};
      vt[5]  = '{1'b0, 1'b1, 14'h0410, 1'b1, 14'h040C, 1'b0, 1'b1, 1'b0};
      vt[6]  = '{1'b0, 1'b1, 14'h0414, 1'b1, 14'h0410, 1'b0, 1'b1, 1'b0};
      vt[7]  = '{1'b0, 1'b1, 14'h0418, 1'b1, 14'h0414, 1'b1, 1'b1, 1'b0};
      vt[8]  = '{1'b0, 1'b1, 14'h0418, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b0};
      vt[9]  = '{1'b0, 1'b1, 14'h0400, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b1};
      vt[10] = '{1'b0, 1'b1, 14'h0400, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; a_start = 1'b0; a_ready = 1'b1; w_start = 1'b0; w_ready = 1'b1;
      #2;
      chk("rst_mem_a", 32'(a_mem_a), 32'h0400);
      chk("rst_valid", 32'(a_valid), 0);
      chk("rst_char",  32'(a_char),  0);
      chk("rst_rgb",   32'(a_rgb),   0);
      chk("rst_last",  32'(a_last),  0);
      chk("rst_busy",  32'(a_busy),  0);
      chk("rst_done",  32'(a_done),  0);
      chk("rst_w_mem_a", 32'(w_mem_a), 32'h3FF8);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         chk($sformatf("scan%0d_mem_a", i), 32'(a_mem_a), 32'(vt[i].mem_a));
         chk($sformatf("scan%0d_valid", i), 32'(a_valid), 32'(vt[i].valid));
         chk($sformatf("scan%0d_busy", i),  32'(a_busy),  32'(vt[i].busy));
         chk($sformatf("scan%0d_done", i),  32'(a_done),  32'(vt[i].done));
         if (vt[i].valid) chk_head_a($sformatf("scan%0d", i), vt[i].head_a, vt[i].last);
         a_start = vt[i].start;
         a_ready = vt[i].ready;
      end

      // backpressure: no pops, FIFO fills after FIFO_DEPTH pushes
      a_ready = 1'b0;
      @(negedge clk) a_start = 1'b1;
      @(negedge clk) a_start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (a_valid) chk_head_a($sformatf("bp_hold%0d", k), 14'h0400, 1'b0);
      end
      chk("bp_mem_a_frozen", 32'(a_mem_a), 32'h0410);
      chk("bp_valid", 32'(a_valid), 1);
      chk("bp_busy",  32'(a_busy),  1);

      // full FIFO: pop without push, then push on the following cycle
      a_ready = 1'b1;
      @(negedge clk);
      chk("full_pop_no_push", 32'(a_mem_a), 32'h0410);
      chk_head_a("full_pop_head", 14'h0404, 1'b0);
      a_ready = 1'b0;
      @(negedge clk);
      chk("full_next_push", 32'(a_mem_a), 32'h0414);

      exp_q = '{14'h0404, 14'h0408, 14'h040C, 14'h0410, 14'h0414};
      a_ready = 1'b1;
      idx = 0;
      for (int k = 0; k < 30 && idx < 5; k++) begin
         if (a_valid) begin
            chk_head_a($sformatf("bp_cell%0d", idx), exp_q[idx], idx == 4);
            idx++;
         end
         @(negedge clk);
      end
      chk("bp_cell_count", 32'(idx), 5);
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         if (a_done) ndone++;
         @(negedge clk);
      end
      chk("bp_done_pulses", 32'(ndone), 1);
      chk("bp_idle", 32'(a_busy), 0);

      // wrap across 0x3FFC, second start issued mid-scan
      @(negedge clk) w_start = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         w_start = (k == 1);
         exp_a = 14'h3FF8 + 14'(4 * k);
         chk($sformatf("wrap%0d_mem_a", k), 32'(w_mem_a), 32'(exp_a));
         if (k >= 1) begin
            w = mem_word(exp_a - 14'd4);
            chk($sformatf("wrap%0d_valid", k), 32'(w_valid), 1);
            chk($sformatf("wrap%0d_char", k),  32'(w_char),  32'(w[7:0]));
            chk($sformatf("wrap%0d_rgb", k),   32'(w_rgb),   32'(w[31:8]));
            chk($sformatf("wrap%0d_last", k),  32'(w_last),  32'(k == 4));
         end
      end
      w_start = 1'b0;
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (w_done) ndone++;
      end
      chk("wrap_done_pulses", 32'(ndone), 1);
      chk("wrap_idle", 32'(w_busy), 0);

      // reset after two cells consumed
      a_ready = 1'b1;
      @(negedge clk) a_start = 1'b1;
      @(negedge clk) a_start = 1'b0;
      pops = 0;
      for (int k = 0; k < 10 && pops < 2; k++) begin
         if (a_valid) pops++;
         @(negedge clk);
      end
      chk("mid_pops", 32'(pops), 2);
      chk("mid_busy_before", 32'(a_busy), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(a_valid), 0);
      chk("mid_rst_busy",  32'(a_busy),  0);
      chk("mid_rst_mem_a", 32'(a_mem_a), 32'h0400);
      chk("mid_rst_char",  32'(a_char),  0);
      @(negedge clk) rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (a_done || a_valid) ndone++;
      end
      chk("mid_no_done", 32'(ndone), 0);
      a_start = 1'b1;
      @(negedge clk) a_start = 1'b0;
      chk("rescan_mem_a0", 32'(a_mem_a), 32'h0400);
      chk("rescan_busy", 32'(a_busy), 1);
      @(negedge clk);
      chk("rescan_valid", 32'(a_valid), 1);
      chk("rescan_mem_a1", 32'(a_mem_a), 32'h0404);
      chk_head_a("rescan_head", 14'h0400, 1'b0);
      repeat (12) @(negedge clk);
      chk("rescan_idle", 32'(a_busy), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
